spi_pwm_expander: RTL and testbench

//  Parametrised SPI-slave PWM expander, next generation of the 4-channel design.
//  N independent PWM channels, each with switch, period and prescaler registers,

---
 rtl/spi_pwm_expander.sv | 182 ++++++++++++++++++
 tb/tb_spi_pwm_expander.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_pwm_expander.sv
// SPI mode-0 slave exposing CHANNELS PWM generators: staged switch/period/prescaler
// registers with period-boundary shadowing, enable/polarity control and MISO read-back.
module spi_pwm_expander #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16
) (
   input  logic                CLK,
   input  logic                _RST,
   input  logic                _CS,
   input  logic                SCLK,
   input  logic                MOSI,
   output logic                MISO,
   output logic [CHANNELS-1:0] PWMOutputs
);
   localparam logic [7:0] CTRL_EN_ADDR  = 8'(6 * CHANNELS);
   localparam logic [7:0] CTRL_POL_ADDR = 8'(6 * CHANNELS + 1);
   localparam int SW  = 0;
   localparam int PER = 1;
   localparam int PRE = 2;

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   state_t state_reg, state_next;

   logic [1:0]          cs_sync_reg, sclk_sync_reg, mosi_sync_reg;
   logic                cs_prev_reg, sclk_prev_reg;
   logic                cs_s, sclk_s, mosi_s;
   logic                cs_fall, cs_high, sclk_rise, sclk_fall, byte_done;
   logic [2:0]          bit_cnt_reg;
   logic [6:0]          rx_reg;
   logic [7:0]          tx_reg, ptr_reg, wr_byte_reg, ptr_new, rd_data;
   logic                wr_pending_reg, wr_is_addr_reg, wr_en, miso_reg;
   logic [CHANNELS-1:0] en_reg, pol_reg;
   logic [15:0]         stg_wide [CHANNELS][3];

   assign cs_s      = cs_sync_reg[1];
   assign sclk_s    = sclk_sync_reg[1];
   assign mosi_s    = mosi_sync_reg[1];
   assign cs_fall   = cs_prev_reg & ~cs_s;
   assign cs_high   = cs_s;
   assign sclk_rise = sclk_s & ~sclk_prev_reg;
   assign sclk_fall = ~sclk_s & sclk_prev_reg;
   assign byte_done = sclk_rise && !cs_high && (state_reg != IDLE) && (bit_cnt_reg == 3'd7);
   assign wr_en     = wr_pending_reg && !wr_is_addr_reg;
   assign ptr_new   = wr_is_addr_reg ? wr_byte_reg : ptr_reg + 8'd1;
   assign MISO      = miso_reg;

   always_ff @(posedge CLK) begin
      if (!_RST) state_reg <= IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (cs_high)
         state_next = IDLE;
      else if (cs_fall)
         state_next = ADDR;
      else if (byte_done && state_reg == ADDR)
         state_next = DATA;
   end

   // Read-back source for the byte that follows: register at the updated pointer.
   always_comb begin
      rd_data = 8'h00;
      for (int c = 0; c < CHANNELS; c++) begin
         for (int k = 0; k < 3; k++) begin
            if (ptr_new == 8'(6 * c + 2 * k))     rd_data = stg_wide[c][k][15:8];
            if (ptr_new == 8'(6 * c + 2 * k + 1)) rd_data = stg_wide[c][k][7:0];
         end
      end
      if (ptr_new == CTRL_EN_ADDR)  rd_data = 8'(en_reg);
      if (ptr_new == CTRL_POL_ADDR) rd_data = 8'(pol_reg);
   end

   always_ff @(posedge CLK) begin
      if (!_RST) begin
         cs_sync_reg    <= '0;
         sclk_sync_reg  <= '0;
         mosi_sync_reg  <= '0;
         cs_prev_reg    <= 1'b0;
         sclk_prev_reg  <= 1'b0;
         bit_cnt_reg    <= '0;
         rx_reg         <= '0;
         tx_reg         <= '0;
         ptr_reg        <= '0;
         wr_byte_reg    <= '0;
         wr_pending_reg <= 1'b0;
         wr_is_addr_reg <= 1'b0;
         miso_reg       <= 1'b0;
         en_reg         <= '0;
         pol_reg        <= '0;
      end else begin
         cs_sync_reg    <= {cs_sync_reg[0], _CS};
         sclk_sync_reg  <= {sclk_sync_reg[0], SCLK};
         mosi_sync_reg  <= {mosi_sync_reg[0], MOSI};
         cs_prev_reg    <= cs_s;
         sclk_prev_reg  <= sclk_s;
         wr_pending_reg <= 1'b0;
         if (cs_high || cs_fall) begin
            bit_cnt_reg <= '0;
            tx_reg      <= '0;
            miso_reg    <= 1'b0;
         end else if (state_reg != IDLE) begin
            if (sclk_rise) begin
               rx_reg      <= {rx_reg[5:0], mosi_s};
               bit_cnt_reg <= bit_cnt_reg + 3'd1;
               if (byte_done) begin
                  wr_pending_reg <= 1'b1;
                  wr_byte_reg    <= {rx_reg, mosi_s};
                  wr_is_addr_reg <= (state_reg == ADDR);
               end
            end
            if (sclk_fall) begin
               miso_reg <= tx_reg[7];
               tx_reg   <= {tx_reg[6:0], 1'b0};
            end
         end
         // A completed byte commits one CLK after its 8th rise, well before the next fall.
         if (wr_pending_reg) begin
            ptr_reg <= ptr_new;
            tx_reg  <= rd_data;
         end
         if (wr_en && ptr_reg == CTRL_EN_ADDR)  en_reg  <= wr_byte_reg[CHANNELS-1:0];
         if (wr_en && ptr_reg == CTRL_POL_ADDR) pol_reg <= wr_byte_reg[CHANNELS-1:0];
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic [CNT_W-1:0] stg_reg [3];
      logic [CNT_W-1:0] act_reg [3];
      logic [15:0]      hi_new  [3];
      logic [15:0]      lo_new  [3];
      logic [CNT_W-1:0] presc_cnt_reg, period_cnt_reg;
      logic             tick, period_end, out_reg;

      for (genvar gk = 0; gk < 3; gk++) begin : g_field
         assign stg_wide[gi][gk] = 16'(stg_reg[gk]);
         assign hi_new[gk]       = {wr_byte_reg, stg_wide[gi][gk][7:0]};
         assign lo_new[gk]       = {stg_wide[gi][gk][15:8], wr_byte_reg};
      end

      assign tick       = (presc_cnt_reg == act_reg[PRE]);
      assign period_end = tick && (period_cnt_reg == act_reg[PER]);

      always_ff @(posedge CLK) begin
         if (!_RST) begin
            for (int k = 0; k < 3; k++) begin
               stg_reg[k] <= '0;
               act_reg[k] <= '0;
            end
            presc_cnt_reg  <= '0;
            period_cnt_reg <= '0;
            out_reg        <= 1'b0;
         end else begin
            for (int k = 0; k < 3; k++) begin
               if (wr_en && ptr_reg == 8'(6 * gi + 2 * k))
                  stg_reg[k] <= hi_new[k][CNT_W-1:0];
               else if (wr_en && ptr_reg == 8'(6 * gi + 2 * k + 1))
                  stg_reg[k] <= lo_new[k][CNT_W-1:0];
            end
            if (!en_reg[gi]) begin
               presc_cnt_reg  <= '0;
               period_cnt_reg <= '0;
               for (int k = 0; k < 3; k++) act_reg[k] <= stg_reg[k];
            end else begin
               if (tick) begin
                  presc_cnt_reg  <= '0;
                  period_cnt_reg <= period_end ? '0 : period_cnt_reg + CNT_W'(1);
               end else begin
                  presc_cnt_reg  <= presc_cnt_reg + CNT_W'(1);
               end
               // Shadow load sees the pre-write staging value if a write lands on this CLK.
               if (period_end)
                  for (int k = 0; k < 3; k++) act_reg[k] <= stg_reg[k];
            end
            out_reg <= en_reg[gi] & ((period_cnt_reg < act_reg[SW]) ^ pol_reg[gi]);
         end
      end

      assign PWMOutputs[gi] = out_reg;
   end
endmodule

// File: tb/tb_spi_pwm_expander.sv
// Directed plus randomized bench: an SPI master drives frames, a register-map model
// predicts MISO bytes, and PWM duty/edge counts are derived arithmetically from the map.
`timescale 1ns/1ps
module tb_spi_pwm_expander;
   localparam int CH = 4;
   localparam int HALF = 8;
   localparam logic [7:0] CTRL_EN  = 8'(6 * CH);
   localparam logic [7:0] CTRL_POL = 8'(6 * CH + 1);

   logic clk = 1'b0;
   logic rst_n, cs_n, sclk, mosi, miso;
   logic [CH-1:0] pwm;
   logic [7:0] mreg [256];
   logic [7:0] frame_tx [$];
   int total, passed;
   int hi, lo, hi2;
   bit ok;

   spi_pwm_expander #(.CHANNELS(CH), .CNT_W(16)) dut (
      .CLK(clk), ._RST(rst_n), ._CS(cs_n), .SCLK(sclk), .MOSI(mosi),
      .MISO(miso), .PWMOutputs(pwm)
   );

   always #5 clk = ~clk;

   initial begin
      #900000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
   endtask

   task automatic model_write(input logic [7:0] a, input logic [7:0] v);
      if (a < CTRL_EN)                       mreg[a] = v;
      else if (a == CTRL_EN || a == CTRL_POL) mreg[a] = v & 8'((1 << CH) - 1);
   endtask

   task automatic spi_bits(input logic [7:0] val, input int nbits);
      for (int b = 7; b > 7 - nbits; b--) begin
         mosi = val[b];
         repeat (HALF) @(negedge clk);
         sclk = 1'b1;
         repeat (HALF) @(negedge clk);
         sclk = 1'b0;
      end
   endtask

   // Full frame from frame_tx; each returned byte is checked against the model.
   task automatic spi_frame(input string tag);
      logic [7:0] exp_q [$];
      logic [7:0] got;
      logic [7:0] p;
      p = frame_tx[0];
      exp_q.push_back(8'h00);
      for (int k = 1; k < frame_tx.size(); k++) begin
         exp_q.push_back(mreg[p]);
         model_write(p, frame_tx[k]);
         p = p + 8'd1;
      end
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      for (int k = 0; k < frame_tx.size(); k++) begin
         got = 8'h00;
         for (int b = 7; b >= 0; b--) begin
            mosi = frame_tx[k][b];
            repeat (HALF) @(negedge clk);
            got[b] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
         end
         check($sformatf("%s miso byte %0d", tag, k), got, exp_q[k]);
      end
      repeat (HALF) @(negedge clk);
      cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      check({tag, " miso idle"}, miso, 0);
   endtask

   task automatic wait_rise(input int ch, input int limit, output bit found);
      int n;
      n = 0;
      @(negedge clk);
      while (pwm[ch] !== 1'b0 && n < limit) begin @(negedge clk); n++; end
      while (pwm[ch] !== 1'b1 && n < limit) begin @(negedge clk); n++; end
      found = (n < limit);
   endtask

   task automatic count_level(input int ch, input logic lvl, input int limit, output int n);
      n = 0;
      while (pwm[ch] === lvl && n < limit) begin n++; @(negedge clk); end
   endtask

   task automatic runs(input int ch, output int h, output int l);
      bit f;
      wait_rise(ch, 400, f);
      h = -1;
      l = -1;
      if (f) begin
         count_level(ch, 1'b1, 400, h);
         count_level(ch, 1'b0, 400, l);
      end
   endtask

   // Phase-independent check: over an integral number of periods the high-sample
   // count and rising-edge count follow directly from the register values.
   task automatic check_window(input int ch, input int periods, input string tag);
      int sw, per, pre, len, base, hp, highs, rises;
      logic en, pol, prev;
      sw   = {mreg[6 * ch], mreg[6 * ch + 1]};
      per  = {mreg[6 * ch + 2], mreg[6 * ch + 3]};
      pre  = {mreg[6 * ch + 4], mreg[6 * ch + 5]};
      en   = mreg[CTRL_EN][ch];
      pol  = mreg[CTRL_POL][ch];
      len  = (pre + 1) * (per + 1);
      base = (sw < per + 1) ? sw : per + 1;
      hp   = en ? (pre + 1) * (pol ? per + 1 - base : base) : 0;
      @(negedge clk);
      prev  = pwm[ch];
      highs = 0;
      rises = 0;
      for (int i = 0; i < periods * len; i++) begin
         @(negedge clk);
         if (pwm[ch] === 1'b1) highs++;
         if (pwm[ch] === 1'b1 && prev === 1'b0) rises++;
         prev = pwm[ch];
      end
      check({tag, " high count"}, highs, periods * hp);
      check({tag, " rising edges"}, rises, (hp > 0 && hp < len) ? periods : 0);
   endtask

   task automatic readback_all(input string tag);
      frame_tx = {};
      frame_tx.push_back(8'h00);
      for (int i = 0; i <= int'(CTRL_POL); i++) frame_tx.push_back(mreg[i]);
      spi_frame(tag);
   endtask

   initial begin
      int rch, rsw, rper, rpre, rpol;
      rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
      total = 0; passed = 0;
      foreach (mreg[i]) mreg[i] = 8'h00;
      repeat (5) @(negedge clk);
      check("reset pwm", pwm, 0);
      check("reset miso", miso, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Channel 0: SWITCH=2, PERIOD=4, PRESC=0
      frame_tx = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00};
      spi_frame("s1 cfg");
      frame_tx = '{CTRL_EN, 8'h01};
      spi_frame("s1 en");
      runs(0, hi, lo);
      check("s1 out0 high run", hi, 2);
      check("s1 out0 low run", lo, 3);

      // Channel 1: SWITCH=1, PERIOD=1, PRESC=4
      frame_tx = '{8'h06, 8'h00, 8'h01, 8'h00, 8'h01, 8'h00, 8'h04};
      spi_frame("s2 cfg");
      frame_tx = '{CTRL_EN, 8'h03};
      spi_frame("s2 en");
      runs(1, hi, lo);
      check("s2 out1 high run", hi, 5);
      check("s2 out1 low run", lo, 5);
      runs(0, hi, lo);
      check("s2 out0 high run", hi, 2);
      check("s2 out0 low run", lo, 3);

      // Read-back of old SWITCH0 while writing 0xAA55 (beyond PERIOD -> full duty)
      frame_tx = '{8'h00, 8'hAA, 8'h55};
      spi_frame("s3 write");
      repeat (20) @(negedge clk);
      check_window(0, 3, "s3 full duty");

      // Long period: switch changed mid-high-phase must not alter the current period
      frame_tx = '{CTRL_EN, 8'h00};
      spi_frame("s3 dis");
      frame_tx = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h09, 8'h00, 8'h63};
      spi_frame("s3 long cfg");
      frame_tx = '{CTRL_EN, 8'h01};
      spi_frame("s3 long en");
      wait_rise(0, 3000, ok);
      check("s3 rise seen", ok, 1);
      fork
         begin
            frame_tx = '{8'h01, 8'h08};
            spi_frame("s3 mid write");
         end
         count_level(0, 1'b1, 3000, hi);
      join
      count_level(0, 1'b0, 3000, lo);
      count_level(0, 1'b1, 3000, hi2);
      check("s3 old high run", hi, 500);
      check("s3 old low run", lo, 500);
      check("s3 new high run", hi2, 800);
      frame_tx = '{CTRL_EN, 8'h00};
      spi_frame("s3 off");

      // Auto-increment and pointer wrap
      frame_tx = '{8'h05, 8'h04, 8'h00};
      spi_frame("s4 presc0");
      frame_tx = '{8'hFF, 8'h11, 8'h22};
      spi_frame("s4 wrap");
      readback_all("s4 readback");

      // Polarity, over-range switch, disable
      frame_tx = '{8'h00, 8'h00, 8'h02, 8'h00, 8'h04, 8'h00, 8'h00};
      spi_frame("s5 cfg");
      frame_tx = '{CTRL_EN, 8'h01, 8'h01};
      spi_frame("s5 en pol");
      runs(0, hi, lo);
      check("s5 inverted high run", hi, 3);
      check("s5 inverted low run", lo, 2);
      frame_tx = '{8'h00, 8'h00, 8'hFF};
      spi_frame("s5 sw ff");
      frame_tx = '{CTRL_POL, 8'h00};
      spi_frame("s5 pol off");
      repeat (20) @(negedge clk);
      check_window(0, 3, "s5 constant high");
      frame_tx = '{CTRL_EN, 8'h00, 8'h01};
      spi_frame("s5 disable");
      check("s5 disabled out0", pwm[0], 0);
      check_window(0, 3, "s5 disabled");

      // Randomized single-channel configurations
      for (int it = 0; it < 6; it++) begin
         rch  = $urandom_range(0, CH - 1);
         rsw  = $urandom_range(0, 9);
         rper = $urandom_range(0, 7);
         rpre = $urandom_range(0, 3);
         rpol = $urandom_range(0, 1);
         frame_tx = '{CTRL_EN, 8'h00};
         spi_frame($sformatf("rnd%0d dis", it));
         frame_tx = '{8'(6 * rch), 8'h00, 8'(rsw), 8'h00, 8'(rper), 8'h00, 8'(rpre)};
         spi_frame($sformatf("rnd%0d cfg", it));
         frame_tx = '{CTRL_EN, 8'(1 << rch), 8'(rpol << rch)};
         spi_frame($sformatf("rnd%0d en", it));
         check_window(rch, 3, $sformatf("rnd%0d ch%0d sw%0d per%0d pre%0d pol%0d",
                                        it, rch, rsw, rper, rpre, rpol));
         check($sformatf("rnd%0d other outputs", it), 32'(pwm & ~CH'(1 << rch)), 0);
      end

      // Aborted partial byte must not disturb anything
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'hA5, 5);
      cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      readback_all("s6 after abort");

      // Reset mid-frame, then a normal frame after a fresh chip select
      cs_n = 1'b0;
      repeat (HALF) @(negedge clk);
      spi_bits(8'h3C, 3);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      foreach (mreg[i]) mreg[i] = 8'h00;
      check("s6 reset pwm", pwm, 0);
      check("s6 reset miso", miso, 0);
      cs_n = 1'b1;
      repeat (2 * HALF) @(negedge clk);
      frame_tx = '{8'h02, 8'h12, 8'h34};
      spi_frame("s6 write");
      frame_tx = '{8'h00, 8'hAB, 8'hCD, 8'hEE, 8'hFF};
      spi_frame("s6 readback");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
